// File: rtl/seq_control.sv
// seq_control: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define SEQ_PERF_EN to build the cycle and retired-instruction counters.
module seq_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk_s,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  op,
    input  logic        zf,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        ir_en,
    output logic        reg_we,
    output logic        ram_re,
    output logic        ram_we,
    output logic        busy,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instr_cnt
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    // Last count value before the limit; a miss here is the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait;
    logic       r_illegal;
    logic       r_timeout;

    logic       w_legal;
    logic       w_busy;
    logic       w_pc_en;
    logic [1:0] w_pc_sel;
    logic       w_ir_en;
    logic       w_reg_we;
    logic       w_ram_re;
    logic       w_ram_we;
    state_t     w_retire;

    assign w_legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                     (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    assign w_busy   = (r_state != S_IDLE) && (r_state != S_HALT);
    assign w_retire = run ? S_FETCH : S_IDLE;

    // Strobes decoded from the current state and the live inputs
    always_comb begin
        w_pc_en  = 1'b0;
        w_pc_sel = 2'b00;
        w_ir_en  = 1'b0;
        w_reg_we = 1'b0;
        w_ram_re = 1'b0;
        w_ram_we = 1'b0;
        case (r_state)
            S_FETCH: w_ir_en = mem_ready;
            S_DECODE: begin
                if (op == OP_J) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = 2'b10;
                end
            end
            S_EXEC: begin
                if (op == OP_BEQ) begin
                    w_pc_en  = 1'b1;
                    w_pc_sel = {1'b0, zf};
                end
            end
            S_MEM: begin
                w_ram_re = (op == OP_LW);
                w_ram_we = (op == OP_SW);
                w_pc_en  = (op == OP_SW) && mem_ready;
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, memory wait counter and sticky fault flags
    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wait    <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_wait  <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        if (r_wait == WAIT_LAST) begin
                            r_state   <= S_HALT;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else if (op == OP_J) begin
                        r_state <= w_retire;
                        r_wait  <= 8'd0;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_BEQ) begin
                        r_state <= w_retire;
                        r_wait  <= 8'd0;
                    end else if (op == OP_LW || op == OP_SW) begin
                        r_state <= S_MEM;
                        r_wait  <= 8'd0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_LW) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= w_retire;
                            r_wait  <= 8'd0;
                        end
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        if (r_wait == WAIT_LAST) begin
                            r_state   <= S_HALT;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    r_state <= w_retire;
                    r_wait  <= 8'd0;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_PERF_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_instr_cnt;

    // Busy-cycle and retired-instruction counters, free-running wrap
    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt   <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            if (w_busy) r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (w_pc_en) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign instr_cnt = r_instr_cnt;
`else
    assign cyc_cnt   = 32'd0;
    assign instr_cnt = 32'd0;
`endif

    assign pc_en   = w_pc_en;
    assign pc_sel  = w_pc_sel;
    assign ir_en   = w_ir_en;
    assign reg_we  = w_reg_we;
    assign ram_re  = w_ram_re;
    assign ram_we  = w_ram_we;
    assign busy    = w_busy;
    assign illegal = r_illegal;
    assign timeout = r_timeout;
    assign state   = r_state;
endmodule

// File: tb/tb_seq_control.sv
// tb_seq_control: per-cycle trace check of seq_control against a
// per-instruction reference model built from the sequencing rules.
module tb_seq_control;
    localparam int T = 4;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

`ifdef SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk_s = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  op = 6'd0;
    logic        zf = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        ir_en;
    logic        reg_we;
    logic        ram_re;
    logic        ram_we;
    logic        busy;
    logic        illegal;
    logic        timeout;
    logic [2:0]  state;
    logic [31:0] cyc_cnt;
    logic [31:0] instr_cnt;

    seq_control #(.MEM_TIMEOUT(T)) dut (
        .clk_s(clk_s), .rst_n(rst_n), .run(run), .op(op), .zf(zf),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_sel(pc_sel),
        .ir_en(ir_en), .reg_we(reg_we), .ram_re(ram_re),
        .ram_we(ram_we), .busy(busy), .illegal(illegal),
        .timeout(timeout), .state(state), .cyc_cnt(cyc_cnt),
        .instr_cnt(instr_cnt)
    );

    always #5 clk_s = ~clk_s;

    // exp: {state, pc_en, pc_sel, ir_en, reg_we, ram_re, ram_we,
    //       busy, illegal, timeout}
    typedef struct packed {
        logic        mr;
        logic        rn;
        logic [5:0]  op;
        logic        z;
        logic [12:0] exp;
    } ent_t;

    ent_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ins = 32'd0;
    logic        m_ill = 1'b0;
    logic        m_to = 1'b0;
    logic [5:0]  ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [12:0] obs();
        return {state, pc_en, pc_sel, ir_en, reg_we, ram_re, ram_we,
                busy, illegal, timeout};
    endfunction

    function automatic void push(logic [2:0] st, logic pe,
                                 logic [1:0] ps, logic ir, logic we,
                                 logic re, logic rw, logic mr,
                                 logic rn, logic [5:0] o, logic z);
        ent_t e;
        logic b;
        b = (st != 3'd0) && (st != 3'd6);
        e.mr  = mr;
        e.rn  = rn;
        e.op  = o;
        e.z   = z;
        e.exp = {st, pe, ps, ir, we, re, rw, b, m_ill, m_to};
        q.push_back(e);
    endfunction

    task automatic idle(input int n, input logic rn);
        for (int i = 0; i < n; i++)
            push(3'd0, 0, 2'b00, 0, 0, 0, 0, rb(), rn, 6'($urandom), rb());
    endtask

    task automatic halt(input int n);
        for (int i = 0; i < n; i++)
            push(3'd6, 0, 2'b00, 0, 0, 0, 0, rb(), rb(), 6'($urandom), rb());
    endtask

    // Expected cycle trace of one instruction, FETCH through retire.
    task automatic gen_instr(input logic [5:0] o, input logic z,
                             input int fw, input int mw, input logic re);
        bit legal;
        bit is_lw;
        bit is_sw;
        int nf;
        int nm;
        legal = (o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
        is_lw = (o == OP_LW);
        is_sw = (o == OP_SW);
        nf = (fw < T) ? fw : T;
        nm = (mw < T) ? mw : T;
        for (int i = 0; i < nf; i++)
            push(3'd1, 0, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, o, rb());
        if (fw >= T) begin
            m_to = 1'b1;
            return;
        end
        push(3'd1, 0, 2'b00, 1, 0, 0, 0, 1'b1, 1'b1, o, rb());
        if (!legal) begin
            push(3'd2, 0, 2'b00, 0, 0, 0, 0, rb(), re, o, rb());
            m_ill = 1'b1;
            return;
        end
        if (o == OP_J) begin
            push(3'd2, 1, 2'b10, 0, 0, 0, 0, rb(), re, o, rb());
            return;
        end
        push(3'd2, 0, 2'b00, 0, 0, 0, 0, rb(), re, o, rb());
        if (o == OP_BEQ) begin
            push(3'd3, 1, {1'b0, z}, 0, 0, 0, 0, rb(), re, o, z);
            return;
        end
        push(3'd3, 0, 2'b00, 0, 0, 0, 0, rb(), re, o, rb());
        if (is_lw || is_sw) begin
            for (int i = 0; i < nm; i++)
                push(3'd4, 0, 2'b00, 0, 0, is_lw, is_sw, 1'b0, re, o, rb());
            if (mw >= T) begin
                m_to = 1'b1;
                return;
            end
            if (is_sw) begin
                push(3'd4, 1, 2'b00, 0, 0, 0, 1, 1'b1, re, o, rb());
                return;
            end
            push(3'd4, 0, 2'b00, 0, 0, 1, 0, 1'b1, re, o, rb());
        end
        push(3'd5, 1, 2'b00, 0, 1, 0, 0, rb(), re, o, rb());
    endtask

    task automatic play(input int n);
        ent_t        e;
        logic [31:0] ec;
        logic [31:0] ei;
        int          k;
        k = 0;
        while (q.size() > 0 && k < n) begin
            e = q.pop_front();
            k++;
            @(negedge clk_s);
            mem_ready = e.mr;
            run       = e.rn;
            op        = e.op;
            zf        = e.z;
            #1;
            ec = PERF ? m_cyc : 32'd0;
            ei = PERF ? m_ins : 32'd0;
            tests++;
            assert (obs() === e.exp) else begin
                fails++;
                $error("FAIL trace t=%0t op=%h obs=%b exp=%b",
                       $time, e.op, obs(), e.exp);
            end
            tests++;
            assert ({cyc_cnt, instr_cnt} === {ec, ei}) else begin
                fails++;
                $error("FAIL counters t=%0t obs=%0d/%0d exp=%0d/%0d",
                       $time, cyc_cnt, instr_cnt, ec, ei);
            end
            if (e.exp[2]) m_cyc++;
            if (e.exp[9]) m_ins++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_s);
        run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        assert ({obs(), cyc_cnt, instr_cnt} === 77'd0) else begin
            fails++;
            $error("FAIL reset obs=%b cyc=%0d ins=%0d exp=0",
                   obs(), cyc_cnt, instr_cnt);
        end
        @(negedge clk_s);
        rst_n = 1'b1;
        m_cyc = 32'd0;
        m_ins = 32'd0;
        m_ill = 1'b0;
        m_to  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] o;
        logic       re;
        #3;
        tests++;
        assert ({obs(), cyc_cnt, instr_cnt} === 77'd0) else begin
            fails++;
            $error("FAIL power_on_reset obs=%b exp=0", obs());
        end
        @(negedge clk_s);
        rst_n = 1'b1;

        idle(1, 1'b1);
        gen_instr(OP_R, 1'b0, 0, 0, 1'b0);
        idle(2, 1'b0);
        play(1000);

        do_reset();
        idle(1, 1'b1);
        gen_instr(OP_LW, 1'b0, 0, 3, 1'b0);
        idle(1, 1'b0);
        play(1000);

        idle(1, 1'b1);
        gen_instr(OP_BEQ, 1'b1, 0, 0, 1'b1);
        gen_instr(OP_BEQ, 1'b0, 1, 0, 1'b1);
        gen_instr(OP_J, 1'b0, 0, 0, 1'b1);
        gen_instr(OP_SW, 1'b0, T - 1, T - 1, 1'b1);
        gen_instr(OP_ADDI, 1'b1, 0, 0, 1'b0);
        idle(2, 1'b0);
        play(1000);

        idle(1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            o  = ops[$urandom_range(0, 5)];
            re = ($urandom_range(0, 3) != 0);
            gen_instr(o, rb(), $urandom_range(0, T - 1),
                      $urandom_range(0, T - 1), re);
            if (!re) begin
                idle($urandom_range(1, 3), 1'b0);
                idle(1, 1'b1);
            end
        end
        gen_instr(OP_ADDI, 1'b0, 0, 0, 1'b0);
        idle(1, 1'b0);
        play(100000);

        do_reset();
        idle(1, 1'b1);
        gen_instr(6'h3F, 1'b0, 0, 0, 1'b1);
        halt(10);
        play(1000);

        do_reset();
        idle(2, 1'b0);
        play(1000);

        do_reset();
        idle(1, 1'b1);
        gen_instr(OP_R, 1'b0, T, 0, 1'b1);
        halt(3);
        play(1000);

        do_reset();
        idle(1, 1'b1);
        gen_instr(OP_R, 1'b0, T - 1, 0, 1'b0);
        idle(1, 1'b0);
        play(1000);

        do_reset();
        idle(1, 1'b1);
        gen_instr(OP_LW, 1'b0, 0, T, 1'b1);
        halt(3);
        play(1000);

        do_reset();
        idle(1, 1'b1);
        gen_instr(OP_R, 1'b0, 0, 0, 1'b1);
        play(3);
        @(negedge clk_s);
        mem_ready = 1'b1;
        run = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        assert (obs() === 13'd0) else begin
            fails++;
            $error("FAIL mid_reset obs=%b exp=0", obs());
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_s);
            #1;
            tests++;
            assert ({obs(), cyc_cnt, instr_cnt} === 77'd0) else begin
                fails++;
                $error("FAIL held_reset obs=%b exp=0", obs());
            end
        end
        run = 1'b0;
        rst_n = 1'b1;
        m_cyc = 32'd0;
        m_ins = 32'd0;
        m_ill = 1'b0;
        m_to  = 1'b0;
        idle(2, 1'b0);
        play(1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_control.md
# seq_control

Multicycle sequencer for the CPU datapath. It steps each instruction through fetch, decode, execute, memory and write-back. It drives the enables for the program counter, instruction register, register bank and data RAM, and it waits on a memory-ready handshake. It sits beside the datapath top level and replaces the single-cycle enables with a state machine. It halts on an illegal opcode or a memory timeout.

## Interface
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready in FETCH or MEM before the block halts (range 1..255).
- clk_s  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute, 0 = stop at the next instruction boundary.
- op  in  6  opcode, inst[31:26], from the latched instruction register.
- zf  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_en  out  1  program counter load.
- pc_sel  out  2  next-PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- ir_en  out  1  instruction register load.
- reg_we  out  1  register bank write.
- ram_re  out  1  data RAM read request.
- ram_we  out  1  data RAM write request.
- busy  out  1  state is neither IDLE nor HALT.
- illegal  out  1  sticky; an undecoded opcode was seen.
- timeout  out  1  sticky; mem_ready did not arrive within MEM_TIMEOUT cycles.
- state  out  3  current state encoding.
- cyc_cnt  out  32  active-cycle counter (see Configuration).
- instr_cnt  out  32  retired-instruction counter (see Configuration).

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is unreachable and recovers to IDLE.
- Legal opcodes:
  - R-type 0x00
  - lw 0x23
  - sw 0x2B
  - beq 0x04
  - j 0x02
  - addi 0x08
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: hold until mem_ready. In the mem_ready cycle, ir_en=1 and next state is DECODE.
- DECODE:
  - Illegal op -> HALT and set illegal.
  - j: pc_en=1, pc_sel=10, then retire.
  - All other legal ops -> EXEC.
- EXEC:
  - beq: pc_en=1, pc_sel = zf ? 01 : 00, then retire.
  - R-type and addi -> WB.
  - lw and sw -> MEM.
- MEM:
  - lw holds ram_re=1 until mem_ready, then -> WB.
  - sw holds ram_we=1 until mem_ready. In that cycle pc_en=1, pc_sel=00, then retire.
- WB: reg_we=1, pc_en=1, pc_sel=00, then retire.
- Retire: next state is FETCH if run=1, otherwise IDLE. run=0 never aborts an instruction already in flight.
- HALT: all enables are 0. The only exit is reset.
- Outputs: all strobes are combinational decodes of state, op, zf and mem_ready. Each strobe is active for exactly one cycle per instruction, except that ram_re and ram_we are held for the whole wait.
- Wait counter:
  - 8-bit; clears on every entry to FETCH or MEM.
  - Increments on each FETCH/MEM cycle that has mem_ready=0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0 -> HALT and set timeout.
  - mem_ready=1 in the same cycle as the limit wins: no timeout.

## Timing
- Reset values (immediate, asynchronous):
  - state=IDLE; illegal=0, timeout=0; wait counter=0; cyc_cnt=0, instr_cnt=0.
  - Consequently every strobe and busy are 0.
- Latency with zero-wait memory (mem_ready tied to 1):
  - j: 2 cycles
  - beq: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each wait cycle in FETCH or MEM adds one cycle.
- IDLE to FETCH: one cycle after run rises.
- Reset asserted mid-instruction: the instruction is abandoned and no strobe fires afterwards.

## Configuration
- SEQ_PERF_EN defined:
  - cyc_cnt increments on every cycle where busy=1.
  - instr_cnt increments on every cycle where pc_en=1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- SEQ_PERF_EN undefined: the counters are not built and cyc_cnt and instr_cnt are tied to 0. The port list is unchanged.

## Test plan
- Reset and start: mem_ready=1, op=0x00, run pulsed from cycle 0 -> states 1,2,3,5. reg_we and pc_en (pc_sel=00) are both high in the WB cycle only.
- lw with 3 wait cycles in MEM: ram_re is high for 4 cycles, then WB. With SEQ_PERF_EN: instr_cnt=1, cyc_cnt=8.
- beq, zf=1 -> pc_sel=01 with pc_en in EXEC. beq, zf=0 -> pc_sel=00. j -> pc_sel=10 in DECODE.
- op=0x3F -> HALT. illegal=1, busy=0, all strobes 0 for the next 10 cycles. After rst_n low then high -> IDLE with illegal=0.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT and timeout=1 after 4 wait cycles. Rerun with mem_ready=1 on the 4th wait cycle -> DECODE and timeout=0.
- run dropped during EXEC of an R-type -> WB completes (reg_we=1), then IDLE and busy=0.
